// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection sequencer: NS main road, EW side road and a pedestrian phase,
// with a free-running tick prescaler, per-phase timer and latched requests.
module traffic_intersection_ctrl #(
    parameter int TICK_DIV   = 4,
    parameter int GREEN_MIN  = 4,
    parameter int YELLOW_T   = 2,
    parameter int ALLRED_T   = 1,
    parameter int EW_GREEN_T = 3,
    parameter int WALK_T     = 3
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       ew_car,
    input  logic       ped_req,
    output logic       ns_red,
    output logic       ns_yel,
    output logic       ns_grn,
    output logic       ew_red,
    output logic       ew_yel,
    output logic       ew_grn,
    output logic       walk,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        NS_GREEN = 3'd0,
        NS_YEL   = 3'd1,
        RED_A    = 3'd2,
        WALK     = 3'd3,
        EW_GREEN = 3'd4,
        EW_YEL   = 3'd5,
        RED_B    = 3'd6
    } state_t;

    localparam logic [7:0] DIV_LAST   = 8'(TICK_DIV - 1);
    localparam logic [7:0] GMIN_LAST  = 8'(GREEN_MIN - 1);
    localparam logic [7:0] YEL_LAST   = 8'(YELLOW_T - 1);
    localparam logic [7:0] AR_LAST    = 8'(ALLRED_T - 1);
    localparam logic [7:0] EWG_LAST   = 8'(EW_GREEN_T - 1);
    localparam logic [7:0] WALK_LAST  = 8'(WALK_T - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] pre;
    logic [7:0] t;
    logic       car_pend;
    logic       ped_pend;
    logic       tick;
    logic       car_any;
    logic       ped_any;
    logic       changing;

    assign tick     = (pre == DIV_LAST);
    // Live request inputs count in the same cycle they are sampled, ahead of the latch.
    assign car_any  = car_pend | ew_car;
    assign ped_any  = ped_pend | ped_req;
    assign changing = (state_nxt != state);

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            NS_GREEN: if (tick && t >= GMIN_LAST && (car_any || ped_any)) state_nxt = NS_YEL;
            NS_YEL:   if (tick && t == YEL_LAST)  state_nxt = RED_A;
            RED_A:    if (tick && t == AR_LAST)   state_nxt = ped_any ? WALK : EW_GREEN;
            WALK:     if (tick && t == WALK_LAST) state_nxt = car_any ? EW_GREEN : RED_B;
            EW_GREEN: if (tick && t == EWG_LAST)  state_nxt = EW_YEL;
            EW_YEL:   if (tick && t == YEL_LAST)  state_nxt = RED_B;
            RED_B:    if (tick && t == AR_LAST)   state_nxt = NS_GREEN;
            default:  state_nxt = RED_B;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values together.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state    <= NS_GREEN;
            pre      <= 8'd0;
            t        <= 8'd0;
            car_pend <= 1'b0;
            ped_pend <= 1'b0;
        end else begin
            state <= state_nxt;
            pre   <= tick ? 8'd0 : pre + 8'd1;

            if (changing)
                t <= 8'd0;
            else if (tick && t != 8'hFF)
                t <= t + 8'd1;

            // Entering the serving phase clears the request even if it is re-asserted now.
            if (changing && state_nxt == EW_GREEN)
                car_pend <= 1'b0;
            else if (ew_car && state != EW_GREEN)
                car_pend <= 1'b1;

            if (changing && state_nxt == WALK)
                ped_pend <= 1'b0;
            else if (ped_req && state != WALK)
                ped_pend <= 1'b1;
        end
    end

    always_comb begin
        ns_red  = 1'b1;
        ns_yel  = 1'b0;
        ns_grn  = 1'b0;
        ew_red  = 1'b1;
        ew_yel  = 1'b0;
        ew_grn  = 1'b0;
        walk    = 1'b0;
        state_o = state;
        case (state)
            NS_GREEN: begin ns_red = 1'b0; ns_grn = 1'b1; end
            NS_YEL:   begin ns_red = 1'b0; ns_yel = 1'b1; end
            EW_GREEN: begin ew_red = 1'b0; ew_grn = 1'b1; end
            EW_YEL:   begin ew_red = 1'b0; ew_yel = 1'b1; end
            WALK:     walk = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Bench for traffic_intersection_ctrl: a cycle-level behavioural model of the phase rules
// checked every cycle on two instances (default timing and all-ones timing).
module tb_traffic_intersection_ctrl;

    logic CLK;
    logic reset, ew_car, ped_req;
    logic reset1, ew_car1, ped_req1;
    logic ns_red0, ns_yel0, ns_grn0, ew_red0, ew_yel0, ew_grn0, walk0;
    logic ns_red1, ns_yel1, ns_grn1, ew_red1, ew_yel1, ew_grn1, walk1;
    logic [2:0] state_o0, state_o1;

    int n_checks = 0;
    int n_errors = 0;

    traffic_intersection_ctrl dut (
        .CLK(CLK), .reset(reset), .ew_car(ew_car), .ped_req(ped_req),
        .ns_red(ns_red0), .ns_yel(ns_yel0), .ns_grn(ns_grn0),
        .ew_red(ew_red0), .ew_yel(ew_yel0), .ew_grn(ew_grn0),
        .walk(walk0), .state_o(state_o0)
    );

    traffic_intersection_ctrl #(
        .TICK_DIV(1), .GREEN_MIN(1), .YELLOW_T(1), .ALLRED_T(1), .EW_GREEN_T(1), .WALK_T(1)
    ) dut_fast (
        .CLK(CLK), .reset(reset1), .ew_car(ew_car1), .ped_req(ped_req1),
        .ns_red(ns_red1), .ns_yel(ns_yel1), .ns_grn(ns_grn1),
        .ew_red(ew_red1), .ew_yel(ew_yel1), .ew_grn(ew_grn1),
        .walk(walk1), .state_o(state_o1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: phase index, ticks seen in the phase, cycles since reset, pendings.
    int p_div[2]  = '{4, 1};
    int p_gmin[2] = '{4, 1};
    int p_yel[2]  = '{2, 1};
    int p_ar[2]   = '{1, 1};
    int p_ewg[2]  = '{3, 1};
    int p_walk[2] = '{3, 1};
    int m_st[2];
    int m_ticks[2];
    int m_cyc[2];
    bit m_car[2];
    bit m_ped[2];
    bit m_valid[2] = '{1'b0, 1'b0};

    task automatic model_step(input int i, input bit rst, input bit car, input bit ped);
        bit tick, car_now, ped_now;
        int nxt;
        if (rst) begin
            m_st[i] = 0; m_ticks[i] = 0; m_cyc[i] = 0;
            m_car[i] = 1'b0; m_ped[i] = 1'b0; m_valid[i] = 1'b1;
            return;
        end
        if (!m_valid[i]) return;
        tick    = (m_cyc[i] % p_div[i]) == p_div[i] - 1;
        car_now = m_car[i] || car;
        ped_now = m_ped[i] || ped;
        nxt     = m_st[i];
        if (tick) begin
            // A phase of D ticks ends on its D-th tick.
            case (m_st[i])
                0: if (m_ticks[i] + 1 >= p_gmin[i] && (car_now || ped_now)) nxt = 1;
                1: if (m_ticks[i] + 1 == p_yel[i])  nxt = 2;
                2: if (m_ticks[i] + 1 == p_ar[i])   nxt = ped_now ? 3 : 4;
                3: if (m_ticks[i] + 1 == p_walk[i]) nxt = car_now ? 4 : 6;
                4: if (m_ticks[i] + 1 == p_ewg[i])  nxt = 5;
                5: if (m_ticks[i] + 1 == p_yel[i])  nxt = 6;
                6: if (m_ticks[i] + 1 == p_ar[i])   nxt = 0;
                default: nxt = 6;
            endcase
        end
        if (car && m_st[i] != 4) m_car[i] = 1'b1;
        if (ped && m_st[i] != 3) m_ped[i] = 1'b1;
        if (nxt == 4 && m_st[i] != 4) m_car[i] = 1'b0;
        if (nxt == 3 && m_st[i] != 3) m_ped[i] = 1'b0;
        if (nxt != m_st[i]) m_ticks[i] = 0;
        else if (tick) m_ticks[i]++;
        m_st[i] = nxt;
        m_cyc[i]++;
    endtask

    // {state, ns r/y/g, ew r/y/g, walk}
    function automatic logic [9:0] expect_vec(input int st);
        logic ns_g, ns_y, ew_g, ew_y, wk;
        ns_g = (st == 0); ns_y = (st == 1);
        ew_g = (st == 4); ew_y = (st == 5);
        wk   = (st == 3);
        return {3'(st), !(ns_g || ns_y), ns_y, ns_g, !(ew_g || ew_y), ew_y, ew_g, wk};
    endfunction

    always @(posedge CLK) begin
        model_step(0, reset, ew_car, ped_req);
        model_step(1, reset1, ew_car1, ped_req1);
    end

    always @(negedge CLK) begin
        if (m_valid[0])
            check($sformatf("dut0_outputs_t%0t", $time),
                  int'({state_o0, ns_red0, ns_yel0, ns_grn0, ew_red0, ew_yel0, ew_grn0, walk0}),
                  int'(expect_vec(m_st[0])));
        if (m_valid[1])
            check($sformatf("dut1_outputs_t%0t", $time),
                  int'({state_o1, ns_red1, ns_yel1, ns_grn1, ew_red1, ew_yel1, ew_grn1, walk1}),
                  int'(expect_vec(m_st[1])));
    end

    task automatic adv();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; reset1 = 1'b1;
        ew_car = 1'b0; ped_req = 1'b0; ew_car1 = 1'b0; ped_req1 = 1'b0;
        adv();
        reset = 1'b0; reset1 = 1'b0;
    endtask

    function automatic int car_only_state(input int k);
        if (k < 16) return 0;
        if (k < 24) return 1;
        if (k < 28) return 2;
        if (k < 40) return 4;
        if (k < 48) return 5;
        if (k < 52) return 6;
        return 0;
    endfunction

    function automatic int car_ped_state(input int k);
        if (k < 16) return 0;
        if (k < 24) return 1;
        if (k < 28) return 2;
        if (k < 40) return 3;
        if (k < 52) return 4;
        if (k < 60) return 5;
        if (k < 64) return 6;
        return 0;
    endfunction

    function automatic bit is_edge_cycle(input int k);
        return k inside {15, 16, 23, 24, 27, 28, 39, 40, 47, 48, 51, 52, 59, 60, 63, 64};
    endfunction

    // Car pulse in cycle 2; runs cycles 0..last-1 with literal checks at phase boundaries.
    task automatic car_only_run(input int last, input string tag);
        for (int k = 0; k < last; k++) begin
            ew_car = (k == 2);
            @(negedge CLK);
            if (is_edge_cycle(k))
                check($sformatf("%s_state_c%0d", tag, k), int'(state_o0), car_only_state(k));
            if (k == 27) check($sformatf("%s_model_carpend_c27", tag), int'(m_car[0]), 1);
            if (k == 28) check($sformatf("%s_model_carpend_c28", tag), int'(m_car[0]), 0);
            adv();
        end
        ew_car = 1'b0;
    endtask

    int fast_seq[8] = '{0, 1, 2, 4, 5, 6, 0, 0};

    initial begin
        reset = 1'b1; reset1 = 1'b1;
        ew_car = 1'b0; ped_req = 1'b0; ew_car1 = 1'b0; ped_req1 = 1'b0;
        adv();
        do_reset();

        // Idle: NS green rests.
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            if (k % 50 == 0) begin
                check($sformatf("idle_state_c%0d", k), int'(state_o0), 0);
                check($sformatf("idle_lamps_c%0d", k), int'({ns_grn0, ew_red0, walk0}), 3'b110);
            end
            adv();
        end

        do_reset();
        car_only_run(60, "car_only");

        // Car + pedestrian.
        do_reset();
        for (int k = 0; k < 70; k++) begin
            ped_req = (k == 1);
            ew_car  = (k == 5);
            @(negedge CLK);
            if (is_edge_cycle(k))
                check($sformatf("car_ped_state_c%0d", k), int'(state_o0), car_ped_state(k));
            if (k == 30) check("car_ped_walk_lamp_c30", int'(walk0), 1);
            adv();
        end
        ped_req = 1'b0; ew_car = 1'b0;

        // Late car after min green; a car during EW green is dropped, so NS then rests.
        do_reset();
        for (int k = 0; k < 101; k++) begin
            ew_car = (k == 30) || (k == 46);
            @(negedge CLK);
            case (k)
                31: check("late_car_c31", int'(state_o0), 0);
                32: check("late_car_c32", int'(state_o0), 1);
                44: check("late_car_c44", int'(state_o0), 4);
                56: check("late_car_c56", int'(state_o0), 5);
                64: check("late_car_c64", int'(state_o0), 6);
                68: check("late_car_c68", int'(state_o0), 0);
                100: check("late_car_rest_c100", int'(state_o0), 0);
                default: ;
            endcase
            adv();
        end
        ew_car = 1'b0;

        // Late pedestrian; a second press during WALK is not latched, so NS then rests.
        do_reset();
        for (int k = 0; k < 101; k++) begin
            ped_req = (k == 30) || (k == 48);
            @(negedge CLK);
            case (k)
                32: check("late_ped_c32", int'(state_o0), 1);
                44: check("late_ped_c44", int'(state_o0), 3);
                56: check("late_ped_c56", int'(state_o0), 6);
                60: check("late_ped_c60", int'(state_o0), 0);
                100: check("late_ped_rest_c100", int'(state_o0), 0);
                default: ;
            endcase
            adv();
        end
        ped_req = 1'b0;

        // Reset in cycle 33 of a car-only run, then the car-only timing repeats.
        do_reset();
        car_only_run(33, "pre_reset");
        reset = 1'b1;
        @(negedge CLK);
        check("midreset_state_c33", int'(state_o0), 4);
        adv();
        reset = 1'b0;
        check("midreset_model_pend", int'({m_car[0], m_ped[0]}), 0);
        car_only_run(60, "post_reset");

        // All-ones timing: one cycle per state.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            ew_car1 = (k == 0);
            @(negedge CLK);
            check($sformatf("fast_seq_c%0d", k), int'(state_o1), fast_seq[k]);
            adv();
        end
        ew_car1 = 1'b0;

        // Randomized traffic, occasional resets, compared every cycle against the model.
        for (int k = 0; k < 4000; k++) begin
            ew_car   = ($urandom_range(0, 19) == 0);
            ped_req  = ($urandom_range(0, 29) == 0);
            ew_car1  = ($urandom_range(0, 3) == 0);
            ped_req1 = ($urandom_range(0, 4) == 0);
            reset    = ($urandom_range(0, 599) == 0);
            reset1   = ($urandom_range(0, 299) == 0);
            adv();
        end
        reset = 1'b0; reset1 = 1'b0;
        ew_car = 1'b0; ped_req = 1'b0; ew_car1 = 1'b0; ped_req1 = 1'b0;
        @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
